// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the timeout counter sizing helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  // $clog2(timeout+1) bits, never narrower than one bit so a disabled timeout still elaborates.
  function automatic int timeout_cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data, legality
// check and sign/zero extension of the load word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  lane,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        bad,
  output logic [31:0] ext
);

  logic        illegal;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    illegal = is_store ? (funct3 > 3'd2)
                       : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    misaligned = 1'b0;
    case (funct3[1:0])
      2'd1:    misaligned = lane[0];
      2'd2:    misaligned = (lane != 2'd0);
      default: misaligned = 1'b0;
    endcase
    bad = illegal | misaligned;
  end

  always_comb begin
    be = 4'b0000;
    case (funct3[1:0])
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = 4'b0011 << lane;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Replicating the datum into every lane lets memory pick it up with be alone.
  always_comb begin
    wdata = 32'd0;
    if (is_store) begin
      case (funct3[1:0])
        2'd0:    wdata = {4{rs2[7:0]}};
        2'd1:    wdata = {2{rs2[15:0]}};
        2'd2:    wdata = rs2;
        default: wdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    ext = 32'd0;
    case (funct3)
      F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext = {{16{half_sel[15]}}, half_sel};
      F3_W:    ext = rdata;
      F3_BU:   ext = {24'd0, byte_sel};
      F3_HU:   ext = {16'd0, half_sel};
      default: ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one data-memory transaction per accepted start, with
// registered outputs, a fault path for bad requests and a ready timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  fsm_state
);

  localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

  // Handshake: mem_req rises the cycle after an accepted start and holds with
  // constant we/addr/be/wdata until a cycle where mem_ready=1; that cycle is
  // the transfer. mem_ready is ignored whenever mem_req is low.

  lsu_state_t       state, state_next;
  logic [2:0]       f3_q;
  logic             store_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [2:0]  a_f3;
  logic        a_store;
  logic [1:0]  a_lane;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        bad;
  logic [31:0] ext;

  logic accept, timed_out, ld_cap;
  logic busy_d, done_d, req_d, we_d, fault_d;

  // Decode the live request while idle, the latched one while accessing.
  assign a_f3    = (state == IDLE) ? funct3     : f3_q;
  assign a_store = (state == IDLE) ? is_store   : store_q;
  assign a_lane  = (state == IDLE) ? addr[1:0]  : lane_q;

  lsu_align u_align (
    .funct3   (a_f3),
    .is_store (a_store),
    .lane     (a_lane),
    .rs2      (store_data),
    .rdata    (mem_rdata),
    .be       (be),
    .wdata    (wdata),
    .bad      (bad),
    .ext      (ext)
  );

  assign accept    = (state == IDLE) && start;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      load_data <= 32'd0;
      cnt       <= '0;
      f3_q      <= 3'd0;
      store_q   <= 1'b0;
      lane_q    <= 2'd0;
    end else begin
      state   <= state_next;
      busy    <= busy_d;
      done    <= done_d;
      fault   <= fault_d;
      mem_req <= req_d;
      mem_we  <= we_d;
      cnt     <= cnt_d;
      if (accept) begin
        f3_q      <= funct3;
        store_q   <= is_store;
        lane_q    <= addr[1:0];
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be;
        mem_wdata <= wdata;
      end
      if (ld_cap) load_data <= ext;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = bad ? DONE : ACCESS;
      ACCESS:  if (mem_ready || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; a completing ready beats a timeout.
  always_comb begin
    busy_d  = (state_next != IDLE);
    done_d  = (state_next == DONE);
    req_d   = (state_next == ACCESS);
    we_d    = req_d && a_store;
    fault_d = (accept && bad) || ((state == ACCESS) && !mem_ready && timed_out);
    ld_cap  = (state == ACCESS) && mem_ready && !store_q;
    cnt_d   = cnt;
    if (state == IDLE) cnt_d = '0;
    else if ((state == ACCESS) && !mem_ready && !timed_out) cnt_d = cnt + CNT_W'(1);
  end

endmodule
